ex_mem_pipe_reg: RTL

//  EX/MEM pipeline register: captures execute-stage results and control each cycle, then drives the

---
 rtl/mips_pkg.sv | 21 ++
 rtl/pipe_field_reg.sv | 25 ++
 rtl/ex_mem_pipe_reg.sv | 139 +++++++++++++
 3 files changed

// File: rtl/mips_pkg.sv
// Shared pipeline definitions: datapath widths, register-zero index and the
// control bundle carried from EX into MEM.
package mips_pkg;

    localparam int DW = 32;
    localparam int RW = 5;

    localparam logic [RW-1:0] REG_ZERO = 5'd0;

    // Control bits that travel with an instruction toward MEM/WB.
    typedef struct packed {
        logic reg_write;
        logic mem_read;
        logic mem_write;
        logic mem_to_reg;
    } ctrl_t;

    localparam int    CTRL_W      = $bits(ctrl_t);
    localparam ctrl_t CTRL_BUBBLE = '{reg_write: 1'b0, mem_read: 1'b0, mem_write: 1'b0, mem_to_reg: 1'b0};

endpackage

// File: rtl/pipe_field_reg.sv
// Generic pipeline field register with synchronous reset, synchronous clear
// and load enable. Reset and clear both force zero; otherwise loads on enable.
module pipe_field_reg #(
    parameter int W = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clear,
    input  logic         en,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    // Priority: reset, then clear, then enable; hold otherwise.
    always_ff @(posedge clk) begin
        if (rst) begin
            q <= '0;
        end else if (clear) begin
            q <= '0;
        end else if (en) begin
            q <= d;
        end
    end

endmodule

// File: rtl/ex_mem_pipe_reg.sv
// EX/MEM pipeline register with stall/flush, late WB->store-data forwarding
// while a store is held, an EX-result forwarding tap and load/store counters.
module ex_mem_pipe_reg
    import mips_pkg::*;
#(
    parameter int DW    = mips_pkg::DW,
    parameter int RW    = mips_pkg::RW,
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             stall,
    input  logic             flush,
    input  logic             ex_valid,
    input  logic [DW-1:0]    ex_alu_result,
    input  logic [DW-1:0]    ex_store_data,
    input  logic [RW-1:0]    ex_rt,
    input  logic [RW-1:0]    ex_rd,
    input  logic             ex_reg_write,
    input  logic             ex_mem_read,
    input  logic             ex_mem_write,
    input  logic             ex_mem_to_reg,
    input  logic             wb_reg_write,
    input  logic [RW-1:0]    wb_rd,
    input  logic [DW-1:0]    wb_data,
    output logic             mem_valid,
    output logic [DW-1:0]    alu_result,
    output logic [DW-1:0]    write_data,
    output logic             MemRead,
    output logic             MemWrite,
    output logic [RW-1:0]    mem_rd,
    output logic             mem_reg_write,
    output logic             mem_mem_to_reg,
    output logic             fwd_valid,
    output logic [RW-1:0]    fwd_rd,
    output logic [DW-1:0]    fwd_data,
    output logic [CNT_W-1:0] load_count,
    output logic [CNT_W-1:0] store_count
);

    logic          load;
    ctrl_t         ctrl_d;
    ctrl_t         ctrl_q;
    logic          valid_q;
    logic [RW-1:0] rt_q;
    logic          wb_fwd_hit;

    // A new instruction enters only when neither flushing nor stalling.
    assign load = ~stall & ~flush;

    // Control is gated by ex_valid so an invalid EX slot becomes a bubble;
    // writes to R0 are dropped here so R0 is never written or forwarded.
    always_comb begin
        ctrl_d            = CTRL_BUBBLE;
        ctrl_d.reg_write  = ex_valid & ex_reg_write & (ex_rd != REG_ZERO[RW-1:0]);
        ctrl_d.mem_read   = ex_valid & ex_mem_read;
        ctrl_d.mem_write  = ex_valid & ex_mem_write;
        ctrl_d.mem_to_reg = ex_valid & ex_mem_to_reg;
    end

    // Valid + control: cleared by flush (bubble), held by stall.
    pipe_field_reg #(.W(1 + CTRL_W)) u_ctrl (
        .clk   (clk),
        .rst   (rst),
        .clear (flush),
        .en    (~stall),
        .d     ({ex_valid, ctrl_d}),
        .q     ({valid_q, ctrl_q})
    );

    // Data fields are don't-care in a bubble, so flush simply holds them.
    pipe_field_reg #(.W(DW)) u_data (
        .clk   (clk),
        .rst   (rst),
        .clear (1'b0),
        .en    (load),
        .d     (ex_alu_result),
        .q     (alu_result)
    );

    pipe_field_reg #(.W(2 * RW)) u_idx (
        .clk   (clk),
        .rst   (rst),
        .clear (1'b0),
        .en    (load),
        .d     ({ex_rd, ex_rt}),
        .q     ({mem_rd, rt_q})
    );

    // A held store picks up a WB result targeting its rt so it stores the newest value.
    assign wb_fwd_hit = ctrl_q.mem_write & wb_reg_write & (wb_rd == rt_q) &
                        (wb_rd != REG_ZERO[RW-1:0]);

    // Store data register: load on normal advance, WB-forward while stalled.
    always_ff @(posedge clk) begin
        if (rst) begin
            write_data <= '0;
        end else if (flush) begin
            write_data <= write_data;
        end else if (stall) begin
            if (wb_fwd_hit) begin
                write_data <= wb_data;
            end
        end else begin
            write_data <= ex_store_data;
        end
    end

    // Event counters advance only on an accepted load of a valid memory op.
    always_ff @(posedge clk) begin
        if (rst) begin
            load_count  <= '0;
            store_count <= '0;
        end else if (load) begin
            if (ex_valid & ex_mem_read) begin
                load_count <= load_count + 1'b1;
            end
            if (ex_valid & ex_mem_write) begin
                store_count <= store_count + 1'b1;
            end
        end
    end

    assign mem_valid      = valid_q;
    assign MemRead        = ctrl_q.mem_read;
    assign MemWrite       = ctrl_q.mem_write;
    assign mem_reg_write  = ctrl_q.reg_write;
    assign mem_mem_to_reg = ctrl_q.mem_to_reg;

    // Forwarding tap: only ALU results (not loads) headed for a non-zero register.
    assign fwd_valid = valid_q & ctrl_q.reg_write & ~ctrl_q.mem_to_reg &
                       (mem_rd != REG_ZERO[RW-1:0]);
    assign fwd_rd    = mem_rd;
    assign fwd_data  = alu_result;

    // A simultaneous load and store request is an illegal encoding.
    ill_mem_op: assert property (@(posedge clk) disable iff (rst) !(ex_mem_read && ex_mem_write));

endmodule
